if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch front end. Consumes the current PC from the PC register, issues pipelined
//  requests to instruction memory, pairs each response with its PC, buffers the pairs and delivers
//  them in order to decode via valid/ready. Drives pc_hold back to the next-PC mux.
// PARAMETERS
//  FIFO_DEPTH  2              fetch-buffer entries (power of 2, >=2)
//  MAX_OUTST   2              max granted requests awaiting response
//  NOP_INST    32'h0000_0013  instruction driven on id_inst when buffer empty (addi x0,x0,0)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst_n        in   1   async active-low reset
//  pc_in        in   32  current PC (PC register output)
//  pc_hold      out  1   1: next-PC mux must reload pc_in (no grant this cycle)
//  flush_i      in   1   redirect; the PC register loads the target on the same edge
//  imem_req     out  1   request valid
//  imem_addr    out  32  request word address (pc_in, bits[1:0] forced 0)
//  imem_gnt     in   1   request accepted when imem_req & imem_gnt
//  imem_rvalid  in   1   response valid; responses arrive in request order, >=1 cycle after grant
//  imem_rdata   in   32  response instruction
//  id_valid     out  1   head entry valid
//  id_ready     in   1   decode accepts head when id_valid & id_ready
//  id_inst      out  32  head instruction (NOP_INST when empty)
//  id_pc        out  32  head PC (`zero_word when empty)
//  id_misalign  out  1   head entry is a misaligned-fetch marker (0 when macro disabled)
// BEHAVIOUR
//  - Reset: imem_req=0, id_valid=0, id_inst=NOP_INST, id_pc=`zero_word, id_misalign=0;
//    outstanding, discard and FIFO counters=0. Reset mid-transaction drops everything; late
//    rvalids after reset are ignored (outstanding==0).
//  - Credit: imem_req = !flush_i && (outstanding + fifo_count) < FIFO_DEPTH && outstanding < MAX_OUTST.
//  - pc_hold = !(imem_req & imem_gnt). pc_in must stay stable while pc_hold=1 and no flush.
//  - On grant, pc_in is pushed into an internal PC queue (depth MAX_OUTST).
//  - On rvalid with discard_cnt==0: pop PC queue, push {pc, rdata, misalign=0} into the FIFO.
//    rvalid with outstanding==0 is a protocol error: ignored, no state change.
//  - Latency: grant in cycle N, rvalid earliest N+1, id_valid earliest N+2 (registered FIFO, no bypass).
//  - Grant and rvalid in the same cycle: outstanding unchanged; both queue ops occur.
//  - FIFO push and pop in the same cycle are always legal; the credit rule guarantees no overflow.
//  - Flush: same cycle imem_req=0; on the edge the FIFO and PC queue clear, id_valid->0,
//    discard_cnt <= outstanding minus (rvalid this cycle ? 1 : 0). While discard_cnt>0 each
//    rvalid is dropped and decrements it. Fetch resumes the next cycle from the new pc_in;
//    new requests may issue while discards are pending (ordering keeps them distinguishable).
//  - Flush while empty and idle: no effect except one cycle with imem_req=0.
// CONFIGURATION
//  IF_MISALIGN_CHECK_EN defined: pc_in[1:0]!=0 suppresses imem_req; once outstanding==0 and
//    discard_cnt==0 and FIFO has space, push one entry {pc_in, NOP_INST, misalign=1}; afterwards
//    pc_hold=1 and no further request until flush_i. Undefined: pc_in[1:0] ignored, id_misalign=0.
// STRUCTURE
//  - Shared header define.v: `zero_word, NOP_INST encoding, PC/instruction widths.
//  - One sub-module: if_fetch_fifo (parameterised sync FIFO, width 65 = pc+inst+misalign,
//    count output, clear input), instantiated for the fetch buffer; the PC queue is a second instance.
// TESTING
//  1 reset: rst_n=0 mid-fetch -> imem_req=0, id_valid=0, id_inst=32'h13, id_pc=0 immediately.
//  2 streaming: pc 0x0,0x4,0x8 gnt=1, rvalid 1-cycle latency, id_ready=1 -> id_pc 0,4,8 in order,
//    one per cycle, first id_valid 2 cycles after first grant.
//  3 backpressure: id_ready=0 -> after 2 entries buffered imem_req=0, pc_hold=1; release -> drains in order.
//  4 flush with 2 outstanding: flush at pc 0x8 redirect 0x100 -> two stale rvalids dropped,
//    first id_pc=0x100.
//  5 gnt stall: gnt=0 for 3 cycles -> pc_hold=1, imem_addr stable at 0x40, no duplicate entries.
//  6 IF_MISALIGN_CHECK_EN: pc_in=0x102 -> no imem_req, one entry id_misalign=1 id_pc=0x102,
//    held until flush.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, reset/NOP encodings and the fetch-buffer entry layout
package if_fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] ZERO_WORD = '0;
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            misalign;
    } fetch_entry_t;
    localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: synchronous FIFO with occupancy count and synchronous clear
module if_fetch_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: pipelined instruction fetch with PC pairing, flush discard and in-order buffer.
// Optional misaligned-PC trapping enabled by defining IF_MISALIGN_CHECK_EN.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int              FIFO_DEPTH = 2,
    parameter int              MAX_OUTST  = 2,
    parameter logic [XLEN-1:0] NOP_INST   = NOP_WORD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_hold,
    input  logic            flush_i,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            id_misalign
);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int QCW = $clog2(MAX_OUTST + 1);
    logic [FCW-1:0] fifo_cnt;
    logic [QCW-1:0] pcq_cnt, discard_cnt;
    logic [XLEN-1:0] pcq_head, outst;
    fetch_entry_t head, push_entry;
    logic gnt_fire, resp_ok, keep, mis_push, misalign, credit, fifo_push;
    // Every granted, unanswered request is either still paired in the PC queue or awaiting discard
    assign outst    = 32'(pcq_cnt) + 32'(discard_cnt);
    assign credit   = (outst + 32'(fifo_cnt) < 32'(FIFO_DEPTH)) && (outst < 32'(MAX_OUTST));
`ifdef IF_MISALIGN_CHECK_EN
    logic mis_done;
    assign misalign = pc_in[1:0] != 2'b00;
    assign mis_push = rst_n && misalign && !mis_done && !flush_i && outst == 0
                      && 32'(fifo_cnt) < 32'(FIFO_DEPTH);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis_done <= 1'b0;
        else if (flush_i) mis_done <= 1'b0;
        else if (mis_push) mis_done <= 1'b1;
    end
`else
    assign misalign = 1'b0;
    assign mis_push = 1'b0;
`endif
    assign imem_req   = rst_n && !flush_i && !misalign && credit;
    assign imem_addr  = {pc_in[XLEN-1:2], 2'b00};
    assign gnt_fire   = imem_req && imem_gnt;
    assign pc_hold    = !gnt_fire;
    assign resp_ok    = imem_rvalid && outst != 0;
    assign keep       = resp_ok && discard_cnt == '0;
    assign fifo_push  = (keep || mis_push) && !flush_i;
    assign push_entry = mis_push ? fetch_entry_t'{pc_in, NOP_INST, 1'b1}
                                 : fetch_entry_t'{pcq_head, imem_rdata, 1'b0};
    assign id_valid    = fifo_cnt != '0;
    assign id_inst     = id_valid ? head.inst : NOP_INST;
    assign id_pc       = id_valid ? head.pc : ZERO_WORD;
    assign id_misalign = id_valid && head.misalign;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) discard_cnt <= '0;
        else if (flush_i) discard_cnt <= QCW'(outst - 32'(resp_ok));
        else if (resp_ok && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
    end
    if_fetch_fifo #(.W(XLEN), .DEPTH(MAX_OUTST)) u_pc_queue (
        .clk(clk), .rst_n(rst_n), .clear(flush_i),
        .push(gnt_fire), .wdata(pc_in), .pop(keep),
        .rdata(pcq_head), .count(pcq_cnt)
    );
    if_fetch_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fetch_buf (
        .clk(clk), .rst_n(rst_n), .clear(flush_i),
        .push(fifo_push), .wdata(push_entry), .pop(id_valid && id_ready),
        .rdata(head), .count(fifo_cnt)
    );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed fetch scenarios with a PC-register model, in-order memory model and
// an expected-entry scoreboard checked at every decode handshake.
module tb_if_fetch_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;
    logic clk = 1'b0, rst_n, flush_i, imem_gnt, imem_rvalid, id_ready;
    logic [31:0] pc_in, imem_rdata;
    logic pc_hold, imem_req, id_valid, id_misalign;
    logic [31:0] imem_addr, id_inst, id_pc;
    int vec = 0, miss = 0, cyc = 0, delivered = 0, first_g, first_v, d0, l0;
    logic [31:0] pc = 0, target = 0;
    logic gnt_en = 0, rsp_en = 0, ready = 0, flush = 0;
    logic [31:0] mem_q[$];
    logic [31:0] dlog[$];
    exp_t exp_q[$];

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_hold(pc_hold), .flush_i(flush_i),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
        .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_misalign(id_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after negedge, observe, let the edge happen, update PC model
    task automatic tick();
        logic hold;
        exp_t e;
        pc_in = pc;
        flush_i = flush;
        imem_gnt = gnt_en;
        id_ready = ready;
        imem_rvalid = rsp_en && mem_q.size() > 0;
        imem_rdata = imem_rvalid ? inst_of(mem_q[0]) : 32'h0;
        #1;
        chk("pc_hold", 32'(pc_hold), 32'(!(imem_req && imem_gnt)));
        if (imem_req && imem_gnt) begin
            mem_q.push_back(imem_addr);
            exp_q.push_back('{pc_in, inst_of(imem_addr), 1'b0});
            if (first_g < 0) first_g = cyc;
        end
        if (id_valid && first_v < 0) first_v = cyc;
        if (imem_rvalid) void'(mem_q.pop_front());
        if (id_valid && id_ready && !flush) begin
            chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("id_pc", id_pc, e.pc);
                chk("id_inst", id_inst, e.inst);
                chk("id_misalign", 32'(id_misalign), 32'(e.mis));
            end
            dlog.push_back(id_pc);
            delivered++;
        end
        if (flush) exp_q.delete();
        hold = pc_hold;
        @(posedge clk);
        if (flush) pc = target;
        else if (!hold) pc = pc + 4;
        cyc++;
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] t);
        flush = 1'b1;
        target = t;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 0; imem_gnt = 0; imem_rvalid = 0; id_ready = 0;
        pc_in = 0; imem_rdata = 0;
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_inst", id_inst, 32'h13);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_mis", 32'(id_misalign), 32'd0);
        rst_n = 1'b1;

        // streaming: 0,4,8 with single-cycle memory latency
        gnt_en = 1; rsp_en = 1; ready = 1; first_g = -1; first_v = -1; d0 = delivered;
        for (int i = 0; i < 20 && pc < 32'hC; i++) tick();
        gnt_en = 0;
        repeat (6) tick();
        chk("stream_latency", 32'(first_v - first_g), 32'd2);
        chk("stream_count", 32'(delivered - d0), 32'd3);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // async reset with two requests outstanding, then stray responses must be ignored
        gnt_en = 1; rsp_en = 0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_valid", 32'(id_valid), 32'd0);
        chk("midrst_inst", id_inst, 32'h13);
        chk("midrst_pc", id_pc, 32'h0);
        exp_q.delete();
        pc = 0;
        @(negedge clk);
        gnt_en = 0; rsp_en = 1; rst_n = 1'b1; d0 = delivered;
        repeat (4) tick();
        chk("stray_valid", 32'(id_valid), 32'd0);
        chk("stray_count", 32'(delivered - d0), 32'd0);

        // backpressure fills the buffer and stops requesting
        gnt_en = 1; rsp_en = 1; ready = 0;
        repeat (6) tick();
        chk("bp_req", 32'(imem_req), 32'd0);
        chk("bp_hold", 32'(pc_hold), 32'd1);
        chk("bp_valid", 32'(id_valid), 32'd1);
        chk("bp_buffered", 32'(exp_q.size()), 32'd2);
        chk("bp_head", id_pc, 32'h0);
        ready = 1; gnt_en = 0; d0 = delivered;
        repeat (4) tick();
        chk("bp_drain", 32'(delivered - d0), 32'd2);

        // grant stall: address held, one request, exactly one entry
        redirect(32'h40);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", imem_addr, 32'h40);
            chk("stall_hold", 32'(pc_hold), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd1);
        end
        d0 = delivered;
        gnt_en = 1; tick(); gnt_en = 0;
        repeat (4) tick();
        chk("stall_count", 32'(delivered - d0), 32'd1);

        // flush with two outstanding, redirect to 0x100
        redirect(32'h0);
        gnt_en = 1; rsp_en = 0;
        tick(); tick();
        chk("outst_limit", 32'(imem_req), 32'd0);
        chk("flush_at_pc", pc, 32'h8);
        rsp_en = 1;
        redirect(32'h100);
        d0 = delivered; l0 = dlog.size();
        for (int i = 0; i < 20 && pc < 32'h108; i++) tick();
        gnt_en = 0;
        repeat (8) tick();
        chk("flush_count", 32'(delivered - d0), 32'd2);
        chk("flush_first_pc", (dlog.size() > l0) ? dlog[l0] : 32'hFFFF_FFFF, 32'h100);

`ifdef IF_MISALIGN_CHECK_EN
        ready = 0;
        redirect(32'h102);
        exp_q.push_back('{32'h102, 32'h13, 1'b1});
        repeat (3) tick();
        chk("mis_req", 32'(imem_req), 32'd0);
        chk("mis_valid", 32'(id_valid), 32'd1);
        chk("mis_flag", 32'(id_misalign), 32'd1);
        chk("mis_pc", id_pc, 32'h102);
        chk("mis_inst", id_inst, 32'h13);
        ready = 1;
        repeat (4) tick();
        chk("mis_single", 32'(exp_q.size()), 32'd0);
        chk("mis_after_valid", 32'(id_valid), 32'd0);
        chk("mis_held", 32'(pc_hold), 32'd1);
        chk("mis_held_req", 32'(imem_req), 32'd0);
        redirect(32'h200);
        tick();
        chk("mis_resume_req", 32'(imem_req), 32'd1);
`else
        redirect(32'h102);
        tick();
        chk("nomis_req", 32'(imem_req), 32'd1);
        chk("nomis_addr", imem_addr, 32'h100);
        chk("nomis_flag", 32'(id_misalign), 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
